// File: rtl/mult_sched_pkg.sv
// Shared types and widths for the two-requester multiplier scheduler.
package mult_sched_pkg;

  localparam int OP_W        = 32;
  localparam int PROD_W      = 64;
  localparam int TIMEOUT_DEF = 128;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_e;

endpackage

// File: rtl/mult_scheduler_if.sv
// Requester and multiplier signals of the scheduler; slave is the scheduler side.
interface mult_scheduler_if;
  import mult_sched_pkg::*;

  logic              req0, req1;
  logic [OP_W-1:0]   a0, b0, a1, b1;
  logic              ack0, ack1;
  logic              rsp_valid0, rsp_valid1;
  logic              rsp_ready0, rsp_ready1;
  logic [PROD_W-1:0] rsp_data;
  logic              rsp_err;
  logic              mul_go;
  logic [OP_W-1:0]   mul_multiplicand, mul_multiplier;
  logic              mul_done;
  logic [PROD_W-1:0] mul_product;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, rsp_ready0, rsp_ready1, mul_done, mul_product,
    output ack0, ack1, rsp_valid0, rsp_valid1, rsp_data, rsp_err,
           mul_go, mul_multiplicand, mul_multiplier
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, rsp_ready0, rsp_ready1, mul_done, mul_product,
    input  ack0, ack1, rsp_valid0, rsp_valid1, rsp_data, rsp_err,
           mul_go, mul_multiplicand, mul_multiplier
  );

endinterface

// File: rtl/mult_scheduler_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one shift-add multiplier between two requesters, with round-robin
// arbitration and a timeout abort while waiting for the multiplier.
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic            CLK,
  input logic            reset,
  mult_scheduler_if.slave bus
);

  // The wait ends when the incremented count reaches TIMEOUT-1, so the
  // abort lands exactly TIMEOUT cycles after the launch cycle.
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT - 2);

  state_e            state_q;
  logic              owner_q;
  logic              last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [OP_W-1:0]   mcand_q, mplier_q;
  logic [PROD_W-1:0] result_q;
  logic              err_q;
  logic              ack0_q, ack1_q, mul_go_q;
  logic              rsp_valid0_q, rsp_valid1_q;

  logic [1:0]        gnt;
  logic              owner_d;
  logic [OP_W-1:0]   mcand_d, mplier_d;
  logic              owner_ready;

  rr_arbiter2 u_arb (
    .req_i  ({bus.req1, bus.req0}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  always_comb begin
    owner_d     = gnt[1];
    mcand_d     = owner_d ? bus.a1 : bus.a0;
    mplier_d    = owner_d ? bus.b1 : bus.b0;
    owner_ready = owner_q ? bus.rsp_ready1 : bus.rsp_ready0;
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;  // "last served = 1" gives requester 0 the first tie
      cnt_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      mul_go_q     <= 1'b0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
    end else begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      mul_go_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (|gnt) begin
            owner_q  <= owner_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            ack0_q   <= gnt[0];
            ack1_q   <= gnt[1];
            mul_go_q <= 1'b1;
            state_q  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mul_done) begin
            result_q     <= bus.mul_product;
            err_q        <= 1'b0;
            rsp_valid0_q <= ~owner_q;
            rsp_valid1_q <= owner_q;
            state_q      <= S_RESP;
          end else if (cnt_q == TERM_CNT) begin
            result_q     <= '0;
            err_q        <= 1'b1;
            rsp_valid0_q <= ~owner_q;
            rsp_valid1_q <= owner_q;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (owner_ready) begin
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            err_q        <= 1'b0;
            last_q       <= owner_q;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ack0             = ack0_q;
  assign bus.ack1             = ack1_q;
  assign bus.mul_go           = mul_go_q;
  assign bus.mul_multiplicand = mcand_q;
  assign bus.mul_multiplier   = mplier_q;
  assign bus.rsp_valid0       = rsp_valid0_q;
  assign bus.rsp_valid1       = rsp_valid1_q;
  assign bus.rsp_data         = result_q;
  assign bus.rsp_err          = err_q;

endmodule
